multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, using these ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
REQ-002 The block SHALL have these inputs:
- opcode  in  6  instr[31:26], sampled from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
REQ-003 The block SHALL drive these write strobes:
- pcWrite  out  1  PC register enable
- irWrite  out  1  instruction register enable
- memWrite  out  1  unified memory write enable
- regWrite  out  1  register file WE3
REQ-004 The block SHALL drive these datapath selects:
- iorD  out  1  memory address select: 0=PC, 1=ALUOut
- regDst  out  2  write register: 00=rt, 01=rd, 10=register 7
- memtoReg  out  2  write data: 00=ALUOut, 01=MDR, 10=PC
- aluSrcA  out  1  ALU operand A: 0=PC, 1=A
- aluSrcB  out  2  ALU operand B: 00=B, 01=constant 4, 10=SignImm, 11=SignImm<<2
- pcSrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump address, 11=latched A
- aluControl  out  5  ALU operation
REQ-005 The block SHALL drive these status outputs:
- state  out  4  current state, for debug
- instrDone  out  1  high in the final cycle of each instruction
- illegalOp  out  1  unsupported opcode/funct flag
- instrCount  out  32  count of retired instructions

Function
REQ-006 aluControl encodings SHALL be: AND=00000, OR=00001, ADD=00010, SUB=00110, SLT=00111.
REQ-007 State encoding SHALL be:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6
- ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, JAL=12, JR=13
- Encodings 14 and 15 are unused; either one SHALL go to FETCH on the next edge.
REQ-008 State transitions SHALL be:
- FETCH->DECODE.
- DECODE by opcode: 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP; 000011 -> JAL.
- DECODE, opcode 000000: funct 001000 -> JR; funct 100000/100010/100100/100101/101010 -> RTEXEC.
- DECODE, anything else -> FETCH.
- MEMADR -> MEMRD if opcode=100011, else MEMWR.
- MEMRD->MEMWB, RTEXEC->ALUWB, ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP, JAL, JR -> FETCH.
REQ-009 Outputs SHALL be a Moore decode of state; pcWrite in BRANCH is the only exception (it depends on zero). Any output not listed for a state SHALL be 0.
REQ-010 FETCH SHALL drive: iorD=0, aluSrcA=0, aluSrcB=01, ADD, pcSrc=00, irWrite=1, pcWrite=1.
REQ-011 DECODE SHALL drive: aluSrcA=0, aluSrcB=11, ADD (branch target captured in ALUOut).
REQ-012 MEMADR and ADDIEXEC SHALL drive: aluSrcA=1, aluSrcB=10, ADD.
REQ-013 Memory states SHALL drive:
- MEMRD: iorD=1.
- MEMWR: iorD=1, memWrite=1.
- MEMWB: regDst=00, memtoReg=01, regWrite=1.
REQ-014 RTEXEC SHALL drive aluSrcA=1, aluSrcB=00, and aluControl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
REQ-015 Write-back states SHALL drive:
- ALUWB: regDst=01, memtoReg=00, regWrite=1.
- ADDIWB: regDst=00, memtoReg=00, regWrite=1.
REQ-016 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, SUB, pcSrc=01, and pcWrite=zero.
REQ-017 Jump states SHALL drive:
- JUMP: pcSrc=10, pcWrite=1.
- JAL: pcSrc=10, pcWrite=1, regDst=10, memtoReg=10, regWrite=1 (link value is PC+4, already held in PC).
- JR: pcSrc=11, pcWrite=1.
REQ-018 Latency in cycles, including FETCH, SHALL be: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; jal 3; jr 3; illegal 2.
REQ-019 instrDone SHALL be 1 in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP, JAL, JR, and in DECODE when the instruction is illegal.
REQ-020 illegalOp SHALL be 1 only in a DECODE cycle whose opcode/funct is unsupported; such an instruction retires as a NOP.
REQ-021 instrCount SHALL increment by 1 on every edge where instrDone=1 and reset=0, and SHALL wrap from FFFFFFFF to 0.

Reset
REQ-022 On a rising edge with reset=1, state SHALL become FETCH and instrCount SHALL become 0, regardless of the current state.
REQ-023 While reset=1, pcWrite, irWrite, memWrite, regWrite, instrDone and illegalOp SHALL all be forced to 0.
REQ-024 Reset asserted mid-instruction SHALL abandon that instruction: no further strobes, and no instrCount increment.
REQ-025 The first cycle after reset deasserts SHALL be FETCH with irWrite=1 and pcWrite=1.

Verification
REQ-026 lw (opcode 100011) after reset:
- states 0,1,2,3,4;
- regWrite=1 with memtoReg=01 only in cycle 5;
- instrCount=1.
REQ-027 beq (000100) run twice:
- zero=1 in BRANCH -> pcWrite=1, pcSrc=01;
- zero=0 in BRANCH -> pcWrite=0;
- both take 3 cycles.
REQ-028 R-type stream:
- funct 100010 -> aluControl=00110 in RTEXEC;
- funct 101010 -> aluControl=00111 in RTEXEC;
- each ALUWB has regDst=01.
REQ-029 Jumps:
- jal (000011) -> JAL with regDst=10, memtoReg=10, regWrite=1, pcWrite=1;
- jr (000000/001000) -> JR with pcSrc=11.
REQ-030 opcode 111111 -> DECODE with illegalOp=1 and instrDone=1 -> FETCH; no regWrite or memWrite.
REQ-031 Reset and wrap:
- reset raised in MEMRD -> next state FETCH, instrCount=0, no regWrite;
- instrCount preloaded via 2^32-1 retirements (or forced) wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch, decode and
// execute phases, plus a retired-instruction counter.
module multicycle_control (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        pcWrite,
   output logic        irWrite,
   output logic        memWrite,
   output logic        regWrite,
   output logic        iorD,
   output logic [1:0]  regDst,
   output logic [1:0]  memtoReg,
   output logic        aluSrcA,
   output logic [1:0]  aluSrcB,
   output logic [1:0]  pcSrc,
   output logic [4:0]  aluControl,
   output logic [3:0]  state,
   output logic        instrDone,
   output logic        illegalOp,
   output logic [31:0] instrCount
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTEXEC   = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11,
      S_JAL      = 4'd12,
      S_JR       = 4'd13,
      S_SPARE14  = 4'd14,
      S_SPARE15  = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00001;
   localparam logic [4:0] ALU_ADD = 5'b00010;
   localparam logic [4:0] ALU_SUB = 5'b00110;
   localparam logic [4:0] ALU_SLT = 5'b00111;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] count_q;

   logic pc_write_c, ir_write_c, mem_write_c, reg_write_c, done_c, illegal_c;

   function automatic logic is_alu_funct(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
             (fn == FN_OR)  || (fn == FN_SLT);
   endfunction

   function automatic logic [4:0] alu_from_funct(input logic [5:0] fn);
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (done_c)
            count_q <= count_q + 32'd1;
      end
   end

   always_comb begin
      state_d     = S_FETCH;
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      mem_write_c = 1'b0;
      reg_write_c = 1'b0;
      done_c      = 1'b0;
      illegal_c   = 1'b0;
      iorD        = 1'b0;
      regDst      = 2'b00;
      memtoReg    = 2'b00;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      pcSrc       = 2'b00;
      aluControl  = ALU_AND;

      case (state_q)
         S_FETCH: begin
            aluSrcB    = 2'b01;
            aluControl = ALU_ADD;
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            // ALU precomputes the branch target into ALUOut while decoding.
            aluSrcB    = 2'b11;
            aluControl = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               OP_JAL:       state_d = S_JAL;
               OP_RTYPE: begin
                  if (funct == FN_JR)
                     state_d = S_JR;
                  else if (is_alu_funct(funct))
                     state_d = S_RTEXEC;
                  else begin
                     illegal_c = 1'b1;
                     done_c    = 1'b1;
                  end
               end
               default: begin
                  illegal_c = 1'b1;
                  done_c    = 1'b1;
               end
            endcase
         end
         S_MEMADR, S_ADDIEXEC: begin
            aluSrcA    = 1'b1;
            aluSrcB    = 2'b10;
            aluControl = ALU_ADD;
            if (state_q == S_ADDIEXEC)
               state_d = S_ADDIWB;
            else if (opcode == OP_LW)
               state_d = S_MEMRD;
            else
               state_d = S_MEMWR;
         end
         S_MEMRD: begin
            iorD    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            memtoReg    = 2'b01;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_MEMWR: begin
            iorD        = 1'b1;
            mem_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_RTEXEC: begin
            aluSrcA    = 1'b1;
            aluControl = alu_from_funct(funct);
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            regDst      = 2'b01;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_BRANCH: begin
            aluSrcA    = 1'b1;
            aluControl = ALU_SUB;
            pcSrc      = 2'b01;
            pc_write_c = zero;
            done_c     = 1'b1;
         end
         S_ADDIWB: begin
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_JUMP: begin
            pcSrc      = 2'b10;
            pc_write_c = 1'b1;
            done_c     = 1'b1;
         end
         S_JAL: begin
            // PC already holds PC+4, so it is the link value.
            pcSrc       = 2'b10;
            pc_write_c  = 1'b1;
            regDst      = 2'b10;
            memtoReg    = 2'b10;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_JR: begin
            pcSrc      = 2'b11;
            pc_write_c = 1'b1;
            done_c     = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are suppressed during reset so an abandoned instruction has no side effects.
   assign pcWrite    = pc_write_c  & ~reset;
   assign irWrite    = ir_write_c  & ~reset;
   assign memWrite   = mem_write_c & ~reset;
   assign regWrite   = reg_write_c & ~reset;
   assign instrDone  = done_c      & ~reset;
   assign illegalOp  = illegal_c   & ~reset;
   assign state      = state_q;
   assign instrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams checked
// cycle by cycle against an instruction-level model of expected control outputs.
module tb_multicycle_control;

   logic        clock = 1'b0;
   logic        reset;
   logic [5:0]  opcode, funct;
   logic        zero;
   logic        pcWrite, irWrite, memWrite, regWrite, iorD, aluSrcA;
   logic [1:0]  regDst, memtoReg, aluSrcB, pcSrc;
   logic [4:0]  aluControl;
   logic [3:0]  state;
   logic        instrDone, illegalOp;
   logic [31:0] instrCount;

   int          tests;
   int          fails;
   logic [31:0] exp_count;

   multicycle_control dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pcWrite(pcWrite), .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite),
      .iorD(iorD), .regDst(regDst), .memtoReg(memtoReg), .aluSrcA(aluSrcA),
      .aluSrcB(aluSrcB), .pcSrc(pcSrc), .aluControl(aluControl), .state(state),
      .instrDone(instrDone), .illegalOp(illegalOp), .instrCount(instrCount)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, memw, regw, iord;
      logic [1:0] regdst, mtr;
      logic       srca;
      logic [1:0] srcb, pcsrc;
      logic [4:0] aluc;
      logic       done, ill;
   } outv_t;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4,
                  K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b001000: return K_ADDI;
         6'b000010: return K_J;
         6'b000011: return K_JAL;
         6'b000000: begin
            if (fn == 6'b001000) return K_JR;
            if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) return K_R;
            return K_ILL;
         end
         default: return K_ILL;
      endcase
   endfunction

   function automatic int path_len(input int k);
      case (k)
         K_LW:    return 5;
         K_SW, K_R, K_ADDI: return 4;
         K_ILL:   return 2;
         default: return 3;
      endcase
   endfunction

   // State visited in cycle idx of an instruction of kind k (cycle 0 is FETCH).
   function automatic logic [3:0] path_state(input int k, input int idx);
      int tail [9][3] = '{'{2, 3, 4}, '{2, 5, 0}, '{6, 7, 0}, '{9, 10, 0},
                          '{8, 0, 0}, '{11, 0, 0}, '{12, 0, 0}, '{13, 0, 0}, '{0, 0, 0}};
      if (idx < 2) return 4'(idx);
      return 4'(tail[k][idx-2]);
   endfunction

   function automatic outv_t exp_out(input logic [3:0] st, input logic z,
                                     input logic [5:0] fn, input bit ill);
      outv_t v = '0;
      v.st = st;
      case (st)
         4'd0:  begin v.srcb = 2'b01; v.aluc = 5'b00010; v.irw = 1; v.pcw = 1; end
         4'd1:  begin v.srcb = 2'b11; v.aluc = 5'b00010; v.ill = ill; v.done = ill; end
         4'd2, 4'd9: begin v.srca = 1; v.srcb = 2'b10; v.aluc = 5'b00010; end
         4'd3:  v.iord = 1;
         4'd4:  begin v.mtr = 2'b01; v.regw = 1; v.done = 1; end
         4'd5:  begin v.iord = 1; v.memw = 1; v.done = 1; end
         4'd6:  begin
            v.srca = 1;
            case (fn)
               6'b100010: v.aluc = 5'b00110;
               6'b100100: v.aluc = 5'b00000;
               6'b100101: v.aluc = 5'b00001;
               6'b101010: v.aluc = 5'b00111;
               default:   v.aluc = 5'b00010;
            endcase
         end
         4'd7:  begin v.regdst = 2'b01; v.regw = 1; v.done = 1; end
         4'd8:  begin v.srca = 1; v.aluc = 5'b00110; v.pcsrc = 2'b01; v.pcw = z; v.done = 1; end
         4'd10: begin v.regw = 1; v.done = 1; end
         4'd11: begin v.pcsrc = 2'b10; v.pcw = 1; v.done = 1; end
         4'd12: begin v.pcsrc = 2'b10; v.pcw = 1; v.regdst = 2'b10; v.mtr = 2'b10;
                      v.regw = 1; v.done = 1; end
         4'd13: begin v.pcsrc = 2'b11; v.pcw = 1; v.done = 1; end
         default: ;
      endcase
      return v;
   endfunction

   function automatic outv_t observed();
      return '{state, pcWrite, irWrite, memWrite, regWrite, iorD, regDst, memtoReg,
               aluSrcA, aluSrcB, pcSrc, aluControl, instrDone, illegalOp};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Runs one instruction from its FETCH cycle; zsel < 0 randomises zero each cycle.
   // Returns at the negedge of the next instruction's first cycle.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel,
                            input int stop_at);
      int k = classify(op, fn);
      opcode = op;
      funct  = fn;
      for (int i = 0; i < path_len(k); i++) begin
         zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
         #1;
         check($sformatf("cyc op=%b fn=%b i=%0d", op, fn, i), 32'(observed()),
               32'(exp_out(path_state(k, i), zero, fn, k == K_ILL)));
         if (i == stop_at) return;
         @(negedge clock);
      end
      exp_count = exp_count + 32'd1;
      check("count", instrCount, exp_count);
   endtask

   logic [5:0] legal_ops [7] = '{6'b100011, 6'b101011, 6'b000100, 6'b001000,
                                 6'b000010, 6'b000011, 6'b000000};
   logic [5:0] r_fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};

   initial begin
      tests = 0;
      fails = 0;
      exp_count = '0;
      reset = 1'b1;
      opcode = '0;
      funct = '0;
      zero = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check("reset_state", {28'd0, state}, 32'd0);
      check("reset_strobes", {26'd0, pcWrite, irWrite, memWrite, regWrite, instrDone, illegalOp}, 32'd0);
      check("reset_count", instrCount, 32'd0);
      reset = 1'b0;

      // Directed instructions
      run_instr(6'b100011, 6'b000000, -1, -1);
      run_instr(6'b101011, 6'b010101, -1, -1);
      run_instr(6'b000100, 6'b000000, 1, -1);
      run_instr(6'b000100, 6'b000000, 0, -1);
      run_instr(6'b000000, 6'b100010, -1, -1);
      run_instr(6'b000000, 6'b101010, -1, -1);
      run_instr(6'b000000, 6'b100100, -1, -1);
      run_instr(6'b000000, 6'b100101, -1, -1);
      run_instr(6'b000000, 6'b100000, -1, -1);
      run_instr(6'b001000, 6'b111111, -1, -1);
      run_instr(6'b000010, 6'b000000, -1, -1);
      run_instr(6'b000011, 6'b000000, -1, -1);
      run_instr(6'b000000, 6'b001000, -1, -1);
      run_instr(6'b111111, 6'b000000, -1, -1);
      run_instr(6'b000000, 6'b000001, -1, -1);

      // Reset raised while lw sits in MEMRD
      run_instr(6'b100011, 6'b000000, -1, 3);
      reset = 1'b1;
      #1;
      check("midrst_strobes", {26'd0, pcWrite, irWrite, memWrite, regWrite, instrDone, illegalOp}, 32'd0);
      @(negedge clock);
      exp_count = '0;
      check("midrst_state", {28'd0, state}, 32'd0);
      check("midrst_count", instrCount, exp_count);
      check("midrst_regwrite", {31'd0, regWrite}, 32'd0);
      reset = 1'b0;
      run_instr(6'b000010, 6'b000000, -1, -1);

      // Counter wrap from all ones
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      exp_count = 32'hFFFF_FFFF;
      run_instr(6'b000010, 6'b000000, -1, -1);
      check("wrap_zero", instrCount, 32'd0);

      // Random instruction stream
      for (int n = 0; n < 150; n++) begin
         logic [5:0] op, fn;
         op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 6)];
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : r_fns[$urandom_range(0, 5)];
         run_instr(op, fn, -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
